// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the rf_alu_ctrl control unit:
// FSM states, opcode/ext fields, ALU codes and the decode bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_PCINC
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_JUMP  = 4'b0100;

  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_JAL  = 4'b1000;
  localparam logic [3:0] EXT_JUMP = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;

  typedef struct packed {
    logic       reg_write;
    logic       shift_or_alu;
    logic       alusrca;
    logic       alusrcb;
    logic       shift_type;
    logic       jump_en;
    logic       jal_en;
    logic       alu_select;
    logic       illegal;
    logic [3:0] alu_op;
  } ctrl_t;

  // The same 4-bit code names an ALU op in both ext and op fields.
  function automatic logic is_alu_code(input logic [3:0] c);
    return c inside {EXT_ADD, EXT_SUB, EXT_AND, EXT_OR,
                     EXT_XOR, EXT_CMP, EXT_MOV};
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] c);
    logic [3:0] r;
    r = ALU_ADD;
    case (c)
      EXT_SUB: r = ALU_SUB;
      EXT_AND: r = ALU_AND;
      EXT_OR:  r = ALU_OR;
      EXT_XOR: r = ALU_XOR;
      EXT_CMP: r = ALU_CMP;
      EXT_MOV: r = ALU_MOV;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Logical ops take a zero-extended imm8, arithmetic ones sign-extend.
  function automatic logic zext_imm(input logic [3:0] c);
    return c inside {EXT_AND, EXT_OR, EXT_XOR};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational IR-to-control decode for rf_alu_ctrl.
// Undefined encodings decode as NOP with the illegal bit raised.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] shamt
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [7:0] imm8;

  assign op   = ir[15:12];
  assign ext  = ir[7:4];
  assign imm8 = ir[7:0];

  // Classify the instruction and build its EXEC-phase controls.
  always_comb begin
    ctrl              = '0;
    ctrl.shift_or_alu = 1'b1;
    ctrl.alusrca      = 1'b1;
    imm               = '0;
    shamt             = '0;
    unique case (1'b1)
      (op == OP_RTYPE) && (ext == EXT_NOP): begin
      end
      (op == OP_RTYPE) && is_alu_code(ext): begin
        ctrl.alu_op    = alu_code(ext);
        ctrl.reg_write = (ext != EXT_CMP);
      end
      is_alu_code(op): begin
        ctrl.alu_op    = alu_code(op);
        ctrl.alusrcb   = 1'b1;
        ctrl.reg_write = (op != EXT_CMP);
        if (zext_imm(op))
          imm = {{(WIDTH-8){1'b0}}, imm8};
        else
          imm = {{(WIDTH-8){imm8[7]}}, imm8};
      end
      (op == OP_SHIFT) && (ext[3:2] == 2'b00): begin
        ctrl.shift_or_alu = 1'b0;
        ctrl.shift_type   = ext[1];
        ctrl.reg_write    = 1'b1;
        shamt = {{(WIDTH-5){ir[4]}}, ir[4:0]};
      end
      (op == OP_JUMP) && (ext == EXT_JAL): begin
        ctrl.alusrca    = 1'b0;
        ctrl.jump_en    = 1'b1;
        ctrl.jal_en     = 1'b1;
        ctrl.alu_select = 1'b1;
      end
      (op == OP_JUMP) && (ext == EXT_JUMP): begin
        ctrl.alusrca    = 1'b0;
        ctrl.jump_en    = 1'b1;
        ctrl.alu_select = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rf_alu_ctrl.sv
// Multicycle fetch/decode/exec/pc-increment controller.
// Optional trap on undefined encodings: ILLEGAL_TRAP_EN.
module rf_alu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_ack,
  input  logic [WIDTH-1:0]   instr_in,
  output logic               mem_req,
  output logic               regWrite,
  output logic               shiftOrALU,
  output logic               alusrca,
  output logic               alusrcb,
  output logic [3:0]         aluControl,
  output logic [REGBITS-1:0] regAddress1,
  output logic [REGBITS-1:0] regAddress2,
  output logic [WIDTH-1:0]   immediate,
  output logic               shiftType,
  output logic [WIDTH-1:0]   shiftDirection,
  output logic               jumpEN,
  output logic               jalEN,
  output logic               ALUselect,
  output logic               illegal_op
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] ir;
  logic             illegal_q;
  logic             trap;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] shamt;

  ctrl_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .ir   (ir),
    .ctrl (ctrl),
    .imm  (imm),
    .shamt(shamt)
  );

  assign trap       = TRAP_EN && ctrl.illegal;
  assign illegal_op = TRAP_EN ? illegal_q : 1'b0;

  // State sequencing, instruction latch and sticky trap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!illegal_q)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= instr_in;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (trap) begin
            illegal_q <= 1'b1;
            state     <= S_IDLE;
          end else if (ctrl.jump_en) begin
            state <= S_FETCH;
          end else begin
            state <= S_PCINC;
          end
        end
        S_PCINC: state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs from state and IR.
  always_comb begin
    mem_req        = 1'b0;
    regWrite       = 1'b0;
    shiftOrALU     = 1'b0;
    alusrca        = 1'b0;
    alusrcb        = 1'b0;
    aluControl     = ALU_ADD;
    regAddress1    = '0;
    regAddress2    = '0;
    immediate      = '0;
    shiftType      = 1'b0;
    shiftDirection = '0;
    jumpEN         = 1'b0;
    jalEN          = 1'b0;
    ALUselect      = 1'b0;
    if (state != S_IDLE) begin
      regAddress1 = ir[8 +: REGBITS];
      regAddress2 = ir[0 +: REGBITS];
    end
    case (state)
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        regWrite       = ctrl.reg_write;
        shiftOrALU     = ctrl.shift_or_alu;
        alusrca        = ctrl.alusrca;
        alusrcb        = ctrl.alusrcb;
        aluControl     = ctrl.alu_op;
        immediate      = imm;
        shiftType      = ctrl.shift_type;
        shiftDirection = shamt;
        jumpEN         = ctrl.jump_en;
        jalEN          = ctrl.jal_en;
        ALUselect      = ctrl.alu_select;
      end
      S_PCINC: begin
        alusrcb    = 1'b1;
        immediate  = {{(WIDTH-1){1'b0}}, 1'b1};
        aluControl = ALU_ADD;
        shiftOrALU = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
